// File: rtl/ysyx_24080006_icache_sa_pkg.sv
// rtl/ysyx_24080006_icache_sa_pkg.sv - shared constants, FSM states and AXI read-channel types for the icache
package ysyx_24080006_icache_sa_pkg;
   localparam int IcacheWays     = 2;
   localparam int IcacheLineSize = 5;
   localparam int IcacheLineNum  = 1;

   localparam logic [1:0] AxiBurstIncr = 2'b01;
   localparam logic [2:0] AxiSize4B    = 3'b010;

   typedef enum logic [1:0] {
      IDLE,
      AR,
      R,
      REPLAY
   } icache_state_e;

   typedef struct packed {
      logic        arvalid;
      logic [31:0] araddr;
      logic [7:0]  arlen;
      logic [2:0]  arsize;
      logic [1:0]  arburst;
      logic        rready;
   } axi_r_m2s_t;

   typedef struct packed {
      logic        arready;
      logic        rvalid;
      logic [31:0] rdata;
      logic        rlast;
   } axi_r_s2m_t;
endpackage

// File: rtl/ysyx_24080006_icache_sa_if.sv
// rtl/ysyx_24080006_icache_sa_if.sv - fetch request/response bundle between core and icache
interface ysyx_24080006_icache_sa_if;
   logic        req_valid;
   logic        req_ready;
   logic [31:0] req_addr;
   logic        rsp_valid;
   logic [31:0] rsp_data;

   modport master (output req_valid, req_addr, input req_ready, rsp_valid, rsp_data);
   modport slave  (input req_valid, req_addr, output req_ready, rsp_valid, rsp_data);
endinterface

// File: rtl/ysyx_24080006_icache_way.sv
// rtl/ysyx_24080006_icache_way.sv - one way: valid bits (reset), tag array, data array with registered word read
module ysyx_24080006_icache_way #(
   parameter int LINE_LOG2 = 5,
   parameter int SETS_LOG2 = 1,
   parameter int IDX_W     = 1,
   parameter int TAG_W     = 26
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic [IDX_W-1:0]     rd_idx_i,
   input  logic [LINE_LOG2-3:0] rd_word_i,
   output logic                 valid_o,
   output logic [TAG_W-1:0]     tag_o,
   output logic [31:0]          data_o,
   input  logic                 wr_en_i,
   input  logic                 fill_i,
   input  logic [IDX_W-1:0]     wr_idx_i,
   input  logic [LINE_LOG2-3:0] wr_word_i,
   input  logic [31:0]          wr_data_i,
   input  logic [TAG_W-1:0]     tag_i,
   input  logic                 inval_i
);
   localparam int SETS  = 1 << SETS_LOG2;
   localparam int WORDS = 1 << (LINE_LOG2 - 2);

   logic [SETS-1:0]  valid_q;
   logic [TAG_W-1:0] tag_q  [SETS];
   logic [31:0]      data_q [SETS][WORDS];

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         valid_q <= '0;
      end else if (inval_i) begin
         valid_q <= '0;
      end else if (fill_i) begin
         valid_q[wr_idx_i] <= 1'b1;
      end
   end

   // Tag and data arrays carry no reset; valid bits alone qualify them.
   always_ff @(posedge clk_i) begin
      if (fill_i) tag_q[wr_idx_i] <= tag_i;
      if (wr_en_i) data_q[wr_idx_i][wr_word_i] <= wr_data_i;
      data_o <= data_q[rd_idx_i][rd_word_i];
   end

   assign valid_o = valid_q[rd_idx_i];
   assign tag_o   = tag_q[rd_idx_i];
endmodule

// File: rtl/ysyx_24080006_icache_sa.sv
// rtl/ysyx_24080006_icache_sa.sv - set-associative instruction cache refilled by AXI INCR bursts
// Define YSYX_24080006_ICACHE_PERF_EN to add hit_cnt_o/miss_cnt_o counters.
module ysyx_24080006_icache_sa
   import ysyx_24080006_icache_sa_pkg::*;
#(
   parameter int WAYS      = IcacheWays,
   parameter int LINE_LOG2 = IcacheLineSize,
   parameter int SETS_LOG2 = IcacheLineNum
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        req_valid_i,
   output logic        req_ready_o,
   input  logic [31:0] req_addr_i,
   output logic        rsp_valid_o,
   output logic [31:0] rsp_data_o,
   input  logic        fence_i_i,
   output axi_r_m2s_t  axi_r_o,
   input  axi_r_s2m_t  axi_r_i
`ifdef YSYX_24080006_ICACHE_PERF_EN
   ,
   output logic [31:0] hit_cnt_o,
   output logic [31:0] miss_cnt_o
`endif
);
   localparam int WORD_W = LINE_LOG2 - 2;
   localparam int IDX_W  = (SETS_LOG2 > 0) ? SETS_LOG2 : 1;
   localparam int TAG_W  = 32 - LINE_LOG2 - SETS_LOG2;
   localparam int WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;
   localparam int SETS   = 1 << SETS_LOG2;
   localparam logic [7:0] ARLEN = 8'((1 << WORD_W) - 1);

   icache_state_e     state_q, state_d;
   logic [31:0]       addr_q, word_q;
   logic [WORD_W-1:0] beat_q;
   logic [WAY_W-1:0]  victim_q, victim_d, hit_way_q, hit_way, rr_cur;
   logic              evict_q, evict_d, hit_q, fence_pend_q;
   logic [WAYS-1:0]   way_valid, way_live, way_hit;
   logic [TAG_W-1:0]  way_tag  [WAYS];
   logic [31:0]       way_data [WAYS];
   logic [IDX_W-1:0]  req_idx, miss_idx;
   logic [TAG_W-1:0]  req_tag, miss_tag;
   logic [WORD_W-1:0] req_word, miss_word;
   logic              accept, lookup_hit, wr_en, fill, inval;

   assign req_idx   = IDX_W'((req_addr_i >> LINE_LOG2) & ((32'd1 << SETS_LOG2) - 32'd1));
   assign req_tag   = TAG_W'(req_addr_i >> (LINE_LOG2 + SETS_LOG2));
   assign req_word  = req_addr_i[LINE_LOG2-1:2];
   assign miss_idx  = IDX_W'((addr_q >> LINE_LOG2) & ((32'd1 << SETS_LOG2) - 32'd1));
   assign miss_tag  = TAG_W'(addr_q >> (LINE_LOG2 + SETS_LOG2));
   assign miss_word = addr_q[LINE_LOG2-1:2];

   // A fence in IDLE wipes the valid bits this cycle, so a same-cycle lookup must already see them gone.
   assign way_live   = way_valid & {WAYS{!fence_i_i}};
   assign accept     = (state_q == IDLE) && req_valid_i;
   assign lookup_hit = |way_hit;
   assign wr_en      = (state_q == R) && axi_r_i.rvalid;
   assign fill       = wr_en && axi_r_i.rlast;
   assign inval      = ((state_q == IDLE) && fence_i_i) ||
                       ((state_q == REPLAY) && (fence_pend_q || fence_i_i));

   for (genvar w = 0; w < WAYS; w++) begin : g_way
      ysyx_24080006_icache_way #(
         .LINE_LOG2(LINE_LOG2), .SETS_LOG2(SETS_LOG2), .IDX_W(IDX_W), .TAG_W(TAG_W)
      ) u_way (
         .clk_i    (clk_i),
         .rst_ni   (rst_ni),
         .rd_idx_i (req_idx),
         .rd_word_i(req_word),
         .valid_o  (way_valid[w]),
         .tag_o    (way_tag[w]),
         .data_o   (way_data[w]),
         .wr_en_i  (wr_en && (victim_q == WAY_W'(w))),
         .fill_i   (fill && (victim_q == WAY_W'(w))),
         .wr_idx_i (miss_idx),
         .wr_word_i(beat_q),
         .wr_data_i(axi_r_i.rdata),
         .tag_i    (miss_tag),
         .inval_i  (inval)
      );
      assign way_hit[w] = way_live[w] && (way_tag[w] == req_tag);
   end

   if (WAYS > 1) begin : g_rr
      logic [WAY_W-1:0] rr_q [SETS];
      always_ff @(posedge clk_i or negedge rst_ni) begin
         if (!rst_ni) begin
            for (int s = 0; s < SETS; s++) rr_q[s] <= '0;
         end else if (fill && evict_q) begin
            rr_q[miss_idx] <= rr_q[miss_idx] + WAY_W'(1);
         end
      end
      assign rr_cur = rr_q[req_idx];
   end else begin : g_dm
      assign rr_cur = '0;
   end

   // Descending scan so the lowest-numbered hit / invalid way wins.
   always_comb begin
      hit_way  = '0;
      victim_d = rr_cur;
      evict_d  = 1'b1;
      for (int w = WAYS - 1; w >= 0; w--) begin
         if (way_hit[w]) hit_way = WAY_W'(w);
         if (!way_live[w]) begin
            victim_d = WAY_W'(w);
            evict_d  = 1'b0;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) state_q <= IDLE;
      else         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (accept && !lookup_hit) state_d = AR;
         AR:      if (axi_r_i.arready) state_d = R;
         R:       if (fill) state_d = REPLAY;
         REPLAY:  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      axi_r_o         = '0;
      axi_r_o.araddr  = {addr_q[31:LINE_LOG2], {LINE_LOG2{1'b0}}};
      axi_r_o.arlen   = ARLEN;
      axi_r_o.arsize  = AxiSize4B;
      axi_r_o.arburst = AxiBurstIncr;
      axi_r_o.arvalid = (state_q == AR);
      axi_r_o.rready  = (state_q == R);
      req_ready_o     = (state_q == IDLE);
      rsp_valid_o     = hit_q || (state_q == REPLAY);
      rsp_data_o      = (state_q == REPLAY) ? word_q : way_data[hit_way_q];
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         hit_q        <= 1'b0;
         hit_way_q    <= '0;
         addr_q       <= '0;
         victim_q     <= '0;
         evict_q      <= 1'b0;
         beat_q       <= '0;
         word_q       <= '0;
         fence_pend_q <= 1'b0;
      end else begin
         hit_q <= accept && lookup_hit;
         if (accept && lookup_hit) hit_way_q <= hit_way;
         if (accept && !lookup_hit) begin
            addr_q   <= req_addr_i;
            victim_q <= victim_d;
            evict_q  <= evict_d;
            beat_q   <= '0;
         end
         if (wr_en) begin
            beat_q <= beat_q + WORD_W'(1);
            if (beat_q == miss_word) word_q <= axi_r_i.rdata;
         end
         if (state_q == REPLAY)                   fence_pend_q <= 1'b0;
         else if (fence_i_i && state_q != IDLE)   fence_pend_q <= 1'b1;
      end
   end

`ifdef YSYX_24080006_ICACHE_PERF_EN
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         hit_cnt_o  <= '0;
         miss_cnt_o <= '0;
      end else if (accept) begin
         if (lookup_hit) hit_cnt_o  <= hit_cnt_o + 32'd1;
         else            miss_cnt_o <= miss_cnt_o + 32'd1;
      end
   end
`endif
endmodule

// File: tb/tb_ysyx_24080006_icache_sa.sv
// tb/tb_ysyx_24080006_icache_sa.sv - scoreboard bench for the icache with an AXI burst memory model
module tb_ysyx_24080006_icache_sa;
   import ysyx_24080006_icache_sa_pkg::*;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic fence = 1'b0;
   axi_r_m2s_t m2s;
   axi_r_s2m_t s2m;
   ysyx_24080006_icache_sa_if bus();
`ifdef YSYX_24080006_ICACHE_PERF_EN
   logic [31:0] hit_cnt, miss_cnt;
`endif

   int checks = 0, failures = 0, cyc = 0;
   int ar_cnt = 0, beats_acc = 0, last_beat_cyc = -1, rsp_cyc = -1, prev_rsp_cyc = -1;
   logic [31:0] last_araddr = '0;
   logic [31:0] exp_q[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   ysyx_24080006_icache_sa dut (
      .clk_i      (clk),
      .rst_ni     (rst_n),
      .req_valid_i(bus.req_valid),
      .req_ready_o(bus.req_ready),
      .req_addr_i (bus.req_addr),
      .rsp_valid_o(bus.rsp_valid),
      .rsp_data_o (bus.rsp_data),
      .fence_i_i  (fence),
      .axi_r_o    (m2s),
      .axi_r_i    (s2m)
`ifdef YSYX_24080006_ICACHE_PERF_EN
      ,
      .hit_cnt_o  (hit_cnt),
      .miss_cnt_o (miss_cnt)
`endif
   );

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return a ^ 32'h5A5A_0000;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h required %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   // Response scoreboard.
   initial begin
      forever begin
         @(negedge clk);
         if (rst_n && bus.rsp_valid) begin
            prev_rsp_cyc = rsp_cyc;
            rsp_cyc = cyc;
            if (exp_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL rsp_unexpected: got %h required no response", bus.rsp_data);
            end else begin
               check("rsp_data", bus.rsp_data, exp_q.pop_front());
            end
         end
      end
   end

   // Memory side: accept AR, then return a full INCR burst with rlast on the final beat.
   initial begin
      bit busy = 0;
      int beat = 0;
      s2m = '0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            s2m = '0;
            busy = 0;
         end else if (!busy) begin
            if (s2m.arready) begin
               s2m.arready = 1'b0;
               busy = 1;
               beat = 0;
               beats_acc = 0;
               ar_cnt++;
               s2m.rvalid = 1'b1;
               s2m.rdata = mem_word(last_araddr);
               s2m.rlast = 1'b0;
            end else if (m2s.arvalid) begin
               check("arlen", {24'd0, m2s.arlen}, 32'd7);
               check("arsize", {29'd0, m2s.arsize}, 32'd2);
               check("arburst", {30'd0, m2s.arburst}, 32'd1);
               last_araddr = m2s.araddr;
               s2m.arready = 1'b1;
            end
         end else begin
            beats_acc++;
            if (s2m.rlast) begin
               last_beat_cyc = cyc;
               s2m = '0;
               busy = 0;
            end else begin
               check("rready", {31'd0, m2s.rready}, 32'd1);
               beat++;
               s2m.rdata = mem_word(last_araddr + 32'(beat * 4));
               s2m.rlast = (beat == 7);
            end
         end
      end
   end

   task automatic issue(input logic [31:0] a, input logic [31:0] expd);
      int n = 0;
      while (!bus.req_ready && n < 300) begin
         tick();
         n++;
      end
      if (!bus.req_ready) begin
         checks++;
         failures++;
         $display("FAIL issue_timeout: req_ready=0 required 1 for addr %h", a);
      end
      bus.req_valid = 1'b1;
      bus.req_addr = a;
      exp_q.push_back(expd);
      tick();
      bus.req_valid = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while ((exp_q.size() != 0 || !bus.req_ready) && n < 300) begin
         tick();
         n++;
      end
      check("drain", {31'd0, (exp_q.size() == 0 && bus.req_ready)}, 32'd1);
   endtask

   task automatic wait_beats(input int ar_target, input int nbeats);
      int n = 0;
      while (!(ar_cnt == ar_target && beats_acc >= nbeats) && n < 300) begin
         tick();
         n++;
      end
      check("beat_wait", {31'd0, (ar_cnt == ar_target && beats_acc >= nbeats)}, 32'd1);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      exp_q.delete();
      #1;
      check("rst_arvalid", {31'd0, m2s.arvalid}, 32'd0);
      check("rst_rready", {31'd0, m2s.rready}, 32'd0);
      check("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
      tick();
      tick();
      rst_n = 1'b1;
      tick();
      check("rst_req_ready", {31'd0, bus.req_ready}, 32'd1);
   endtask

   initial begin
      bus.req_valid = 1'b0;
      bus.req_addr = '0;
      tick();
      do_reset();

      // Cold miss on word 1 of line 0x3000_0000.
      issue(32'h3000_0004, 32'h6A5A_0004);
      drain();
      check("ar_cnt_cold", ar_cnt, 1);
      check("araddr_cold", last_araddr, 32'h3000_0000);
      check("rsp_at_replay", rsp_cyc - last_beat_cyc, 0);

      // Back-to-back hits, one response per cycle, no new AR.
      issue(32'h3000_0000, 32'h6A5A_0000);
      issue(32'h3000_0008, 32'h6A5A_0008);
      drain();
      check("hit_pair_gap", rsp_cyc - prev_rsp_cyc, 1);
      check("ar_cnt_hits", ar_cnt, 1);

      // Set 0 conflict: 0x40 fills way 1, 0x80 evicts way 0.
      issue(32'h3000_0040, 32'h6A5A_0040);
      drain();
      check("ar_cnt_way1", ar_cnt, 2);
      issue(32'h3000_0080, 32'h6A5A_0080);
      drain();
      check("ar_cnt_evict", ar_cnt, 3);
      issue(32'h3000_0044, 32'h6A5A_0044);
      drain();
      check("ar_cnt_second_hits", ar_cnt, 3);
      issue(32'h3000_0000, 32'h6A5A_0000);
      drain();
      check("ar_cnt_first_misses", ar_cnt, 4);
      check("araddr_first", last_araddr, 32'h3000_0000);

      // Fence during beat 3: refill still answers, then the line is gone.
      issue(32'h3000_0024, 32'h6A5A_0024);
      wait_beats(5, 3);
      fence = 1'b1;
      tick();
      fence = 1'b0;
      drain();
      check("ar_cnt_fence_fill", ar_cnt, 5);
      issue(32'h3000_0024, 32'h6A5A_0024);
      drain();
      check("ar_cnt_after_fence", ar_cnt, 6);

      // Reset after beat 2 abandons the refill.
      issue(32'h3000_0064, 32'h6A5A_0064);
      wait_beats(7, 2);
      do_reset();
      issue(32'h3000_0064, 32'h6A5A_0064);
      drain();
      check("ar_cnt_after_reset", ar_cnt, 8);
      check("araddr_after_reset", last_araddr, 32'h3000_0060);

`ifdef YSYX_24080006_ICACHE_PERF_EN
      do_reset();
      check("perf_hit_rst", hit_cnt, 32'd0);
      check("perf_miss_rst", miss_cnt, 32'd0);
      issue(32'h3000_0100, 32'h6A5A_0100);
      issue(32'h3000_0104, 32'h6A5A_0104);
      issue(32'h3000_0108, 32'h6A5A_0108);
      issue(32'h3000_010C, 32'h6A5A_010C);
      issue(32'h3000_0120, 32'h6A5A_0120);
      issue(32'h3000_0124, 32'h6A5A_0124);
      issue(32'h3000_0128, 32'h6A5A_0128);
      drain();
      check("perf_miss", miss_cnt, 32'd2);
      check("perf_hit", hit_cnt, 32'd5);
`endif

      tick();
      check("queue_empty", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time exceeded");
      $fatal(1, "watchdog");
   end
endmodule
